fetch_stage: RTL and testbench

Instruction fetch stage directly upstream of the instruction memory and downstream-feeding the decode stage.
- Owns the program counter and drives the word address into the instruction memory.
- Captures the returned 24-bit instruction into an IF/ID output register using a valid/ready handshake.
- Handles branch/jump redirects, decode back-pressure, a halt instruction, and a fetched-instruction counter.

---
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory address/data, redirect request and the
// IF/ID valid/ready handshake towards decode.
interface fetch_stage_if #(
    parameter int N     = 24,
    parameter int CNT_W = 16
);
    logic [N-1:0]     pc_addr;
    logic [N-1:0]     instr_in;
    logic             redirect_valid;
    logic [N-1:0]     redirect_addr;
    logic             dec_ready;
    logic             dec_valid;
    logic [N-1:0]     dec_instr;
    logic [N-1:0]     dec_pc;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        output pc_addr, dec_valid, dec_instr, dec_pc, halted, fetch_count,
        input  instr_in, redirect_valid, redirect_addr, dec_ready
    );

    modport slave (
        input  pc_addr, dec_valid, dec_instr, dec_pc, halted, fetch_count,
        output instr_in, redirect_valid, redirect_addr, dec_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, captures memory data into the IF/ID
// register under valid/ready, handles redirects, halt and a fetch counter.
module fetch_stage #(
    parameter int           N          = 24,
    parameter int           MEM_DEPTH  = 1024,
    parameter logic [N-1:0] RESET_PC   = '0,
    parameter logic [N-1:0] HALT_INSTR = 24'hFFFFFF,
    parameter int           CNT_W      = 16
) (
    input logic          clk,
    input logic          reset,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     pc_p0, pc_p0_nxt;
    logic [N-1:0]     instr_p1, instr_p1_nxt;
    logic [N-1:0]     pc_p1, pc_p1_nxt;
    logic             vld_p1, vld_p1_nxt;
    logic [CNT_W-1:0] cnt_p1, cnt_p1_nxt;
    logic             acc;
    logic             redir;

    function automatic logic [N-1:0] pc_incr(input logic [N-1:0] pc);
        return (pc == N'(MEM_DEPTH - 1)) ? '0 : pc + N'(1);
    endfunction

    function automatic logic [N-1:0] wrap_addr(input logic [N-1:0] a);
        return a % N'(MEM_DEPTH);
    endfunction

    function automatic logic [CNT_W-1:0] sat_incr(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign acc   = (state == RUN) && (!vld_p1 || bus.dec_ready) && !bus.redirect_valid;
    assign redir = bus.redirect_valid && (state != BOOT);

    always_comb begin
        state_nxt    = state;
        pc_p0_nxt    = pc_p0;
        instr_p1_nxt = instr_p1;
        pc_p1_nxt    = pc_p1;
        vld_p1_nxt   = vld_p1;
        cnt_p1_nxt   = cnt_p1;

        // Decode may drain the IF/ID entry while no refill is possible.
        if (state != RUN && vld_p1 && bus.dec_ready)
            vld_p1_nxt = 1'b0;

        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (acc) begin
                    instr_p1_nxt = bus.instr_in;
                    pc_p1_nxt    = pc_p0;
                    vld_p1_nxt   = 1'b1;
                    cnt_p1_nxt   = sat_incr(cnt_p1);
                    if (bus.instr_in == HALT_INSTR)
                        state_nxt = HALT;
                    else
                        pc_p0_nxt = pc_incr(pc_p0);
                end
            end
            HALT: state_nxt = HALT;
            default: state_nxt = BOOT;
        endcase

        // Redirect wins over everything and flushes IF/ID, even mid-handshake.
        if (redir) begin
            pc_p0_nxt  = wrap_addr(bus.redirect_addr);
            vld_p1_nxt = 1'b0;
            state_nxt  = RUN;
        end
    end

    // p0: program counter / p1: IF/ID register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            pc_p0    <= RESET_PC;
            instr_p1 <= '0;
            pc_p1    <= '0;
            vld_p1   <= 1'b0;
            cnt_p1   <= '0;
        end else begin
            state    <= state_nxt;
            pc_p0    <= pc_p0_nxt;
            instr_p1 <= instr_p1_nxt;
            pc_p1    <= pc_p1_nxt;
            vld_p1   <= vld_p1_nxt;
            cnt_p1   <= cnt_p1_nxt;
        end
    end

    assign bus.pc_addr     = pc_p0;
    assign bus.dec_valid   = vld_p1;
    assign bus.dec_instr   = instr_p1;
    assign bus.dec_pc      = pc_p1;
    assign bus.halted      = (state == HALT);
    assign bus.fetch_count = cnt_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle table of handshake/redirect/halt/wrap vectors,
// delivery scoreboard, and async reset checks.
module tb_fetch_stage;

    logic clk;
    logic reset;
    logic [23:0] mem [0:1023];

    fetch_stage_if #(.N(24), .CNT_W(16)) bus ();

    fetch_stage #(
        .N(24), .MEM_DEPTH(1024), .RESET_PC(24'd0),
        .HALT_INSTR(24'hFFFFFF), .CNT_W(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.instr_in = mem[bus.pc_addr[9:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [23:0] ra;
        logic        ev;
        logic [23:0] ei;
        logic [23:0] ep;
        logic [23:0] epa;
        logic        eh;
        int          ec;
    } vec_t;

    typedef struct {
        logic [23:0] instr;
        logic [23:0] pc;
    } exp_t;

    vec_t tv [27];
    exp_t sbq [$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input int rdy, input int rv, input int ra, input int ev,
                                input int ep, input int epa, input int eh, input int ec);
        vec_t v;
        v.rdy = rdy[0];
        v.rv  = rv[0];
        v.ra  = ra[23:0];
        v.ev  = ev[0];
        v.ep  = ep[23:0];
        v.ei  = mem[ep[9:0]];
        v.epa = epa[23:0];
        v.eh  = eh[0];
        v.ec  = ec;
        return v;
    endfunction

    function automatic void push_exp(input int pc);
        exp_t e;
        e.pc    = pc[23:0];
        e.instr = mem[pc[9:0]];
        sbq.push_back(e);
    endfunction

    task automatic run_row(input int i);
        logic pre_v, pre_r;
        exp_t e;
        bus.dec_ready      = tv[i].rdy;
        bus.redirect_valid = tv[i].rv;
        bus.redirect_addr  = tv[i].ra;
        pre_v = bus.dec_valid;
        pre_r = tv[i].rdy;
        @(posedge clk);
        #1;
        // A new IF/ID entry appears when the slot was empty or just consumed.
        if (bus.dec_valid && (!pre_v || pre_r)) begin
            if (sbq.size() == 0) begin
                chk($sformatf("row%0d sb_unexpected_pc", i), bus.dec_pc, 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("row%0d sb_instr", i), bus.dec_instr, e.instr);
                chk($sformatf("row%0d sb_pc", i), bus.dec_pc, e.pc);
            end
        end
        chk($sformatf("row%0d dec_valid", i), bus.dec_valid, tv[i].ev);
        if (tv[i].ev) begin
            chk($sformatf("row%0d dec_instr", i), bus.dec_instr, tv[i].ei);
            chk($sformatf("row%0d dec_pc", i), bus.dec_pc, tv[i].ep);
        end
        chk($sformatf("row%0d pc_addr", i), bus.pc_addr, tv[i].epa);
        chk($sformatf("row%0d halted", i), bus.halted, tv[i].eh);
        if (tv[i].ec >= 0)
            chk($sformatf("row%0d fetch_count", i), bus.fetch_count, tv[i].ec[31:0]);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 24'hA00000 | 24'(i);
        mem[0] = 24'h000011;
        mem[1] = 24'h000022;
        mem[2] = 24'h000033;
        mem[3] = 24'h000044;
        mem[5] = 24'hFFFFFF;

        //          rdy rv  ra   ev ep    epa  eh ec
        tv[0]  = mk(1, 0, 0,    0, 0,    0,   0, 0);   // BOOT cycle
        tv[1]  = mk(1, 0, 0,    1, 0,    1,   0, 1);
        tv[2]  = mk(1, 0, 0,    1, 1,    2,   0, 2);
        tv[3]  = mk(0, 0, 0,    1, 1,    2,   0, 2);   // stall x3
        tv[4]  = mk(0, 0, 0,    1, 1,    2,   0, 2);
        tv[5]  = mk(0, 0, 0,    1, 1,    2,   0, 2);
        tv[6]  = mk(1, 0, 0,    1, 2,    3,   0, 3);
        tv[7]  = mk(1, 0, 0,    1, 3,    4,   0, 4);
        tv[8]  = mk(0, 0, 0,    1, 3,    4,   0, 4);
        tv[9]  = mk(0, 1, 10,   0, 0,    10,  0, 4);   // redirect during stall
        tv[10] = mk(0, 0, 0,    1, 10,   11,  0, 5);
        tv[11] = mk(1, 1, 4,    0, 0,    4,   0, 5);   // redirect while consumed
        tv[12] = mk(1, 0, 0,    1, 4,    5,   0, 6);
        tv[13] = mk(1, 0, 0,    1, 5,    5,   1, 7);   // halt delivered
        tv[14] = mk(1, 0, 0,    0, 0,    5,   1, 7);
        tv[15] = mk(1, 0, 0,    0, 0,    5,   1, 7);
        tv[16] = mk(1, 1, 0,    0, 0,    0,   0, 7);   // leave HALT
        tv[17] = mk(1, 0, 0,    1, 0,    1,   0, 8);
        tv[18] = mk(1, 1, 1023, 0, 0,    1023,0, 8);   // wrap
        tv[19] = mk(1, 0, 0,    1, 1023, 0,   0, 9);
        tv[20] = mk(1, 0, 0,    1, 0,    1,   0, 10);
        tv[21] = mk(1, 0, 0,    1, 1,    2,   0, 11);
        tv[22] = mk(1, 1, 1030, 0, 0,    6,   0, 11);  // target taken mod depth
        tv[23] = mk(0, 0, 0,    1, 6,    7,   0, 12);
        tv[24] = mk(0, 1, 50,   0, 0,    0,   0, 0);   // BOOT ignores redirect
        tv[25] = mk(0, 1, 50,   0, 0,    50,  0, 0);
        tv[26] = mk(1, 0, 0,    1, 50,   51,  0, 1);

        push_exp(0); push_exp(1); push_exp(2); push_exp(3);
        push_exp(10); push_exp(4); push_exp(5); push_exp(0);
        push_exp(1023); push_exp(0); push_exp(1); push_exp(6);

        reset              = 1'b1;
        bus.dec_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        #2;
        chk("rst dec_valid", bus.dec_valid, 0);
        chk("rst pc_addr", bus.pc_addr, 0);
        chk("rst dec_instr", bus.dec_instr, 0);
        chk("rst dec_pc", bus.dec_pc, 0);
        chk("rst halted", bus.halted, 0);
        chk("rst fetch_count", bus.fetch_count, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i <= 23; i++) run_row(i);

        // Async reset between edges with an instruction held at pc_addr=7.
        #2;
        reset = 1'b1;
        #1;
        chk("async dec_valid", bus.dec_valid, 0);
        chk("async pc_addr", bus.pc_addr, 0);
        chk("async fetch_count", bus.fetch_count, 0);
        chk("async halted", bus.halted, 0);
        chk("async dec_pc", bus.dec_pc, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        push_exp(50);
        for (int i = 24; i <= 26; i++) run_row(i);

        chk("sb_remaining", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
